// File: rtl/demux_2_skid_pkg.sv
// Shared constants for the demux_2_skid steering stage: skid-buffer state
// encoding and destination select values.
package demux_2_skid_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/demux_2_skid_if.sv
// Handshake bundle for demux_2_skid: one tagged input stream, two output streams.
// master = upstream producer plus both consumers; slave = the steering stage.
interface demux_2_skid_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] a_data;
  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] b_data;

  modport master (
    output in_valid, in_data, in_sel, a_ready, b_ready,
    input  in_ready, a_valid, a_data, b_valid, b_data
  );

  modport slave (
    input  in_valid, in_data, in_sel, a_ready, b_ready,
    output in_ready, a_valid, a_data, b_valid, b_data
  );
endinterface

// File: rtl/demux_2_skid_skid_reg.sv
// Generic 2-entry valid/ready skid buffer (main + skid register) with fully
// registered outputs; in_ready is a flop so it never follows out_ready combinationally.
module skid_reg
  import demux_2_skid_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  state_t       state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         ready_q;
  logic         in_fire, out_fire;

  assign in_fire  = in_valid_i & ready_q;
  assign out_fire = (state_q != ST_EMPTY) & out_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= (state_d != ST_FULL);
    end
  end

  // Payload registers load only on an accepted beat, so idle-bus garbage never enters.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          main_d  = in_data_i;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        case ({in_fire, out_fire})
          2'b10: begin
            skid_d  = in_data_i;
            state_d = ST_FULL;
          end
          2'b01: state_d = ST_EMPTY;
          2'b11: main_d = in_data_i;
          default: ;
        endcase
      end
      ST_FULL: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = (state_q != ST_EMPTY);
  assign out_data_o  = main_q;

endmodule

// File: rtl/demux_2_skid.sv
// Registered 1-to-2 steering stage: buffers {sel, data} and presents the head beat on A or B.
// Optional per-port transfer counters are enabled with DEMUX_2_SKID_STATS_EN.
module demux_2_skid
  import demux_2_skid_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  demux_2_skid_if.slave       bus
`ifdef DEMUX_2_SKID_STATS_EN
  ,
  input  logic                cnt_clr,
  output logic [31:0]         cnt_a,
  output logic [31:0]         cnt_b
`endif
);

  logic             head_valid;
  logic             head_ready;
  logic [WIDTH:0]   head_payload;
  logic             head_sel;
  logic [WIDTH-1:0] head_data;

  skid_reg #(.W(WIDTH + 1)) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (bus.in_valid),
    .in_ready_o  (bus.in_ready),
    .in_data_i   ({bus.in_sel, bus.in_data}),
    .out_valid_o (head_valid),
    .out_ready_i (head_ready),
    .out_data_o  (head_payload)
  );

  assign head_sel  = head_payload[WIDTH];
  assign head_data = head_payload[WIDTH-1:0];

  // Only the addressed consumer's ready matters; this is what enforces head-of-line blocking.
  assign head_ready  = (head_sel == SEL_B) ? bus.b_ready : bus.a_ready;

  assign bus.a_valid = head_valid & (head_sel == SEL_A);
  assign bus.b_valid = head_valid & (head_sel == SEL_B);
  assign bus.a_data  = head_data;
  assign bus.b_data  = head_data;

`ifdef DEMUX_2_SKID_STATS_EN
  logic [31:0] cnt_a_q, cnt_a_d;
  logic [31:0] cnt_b_q, cnt_b_d;
  logic        a_fire, b_fire;

  assign a_fire = bus.a_valid & bus.a_ready;
  assign b_fire = bus.b_valid & bus.b_ready;

  // A clear coinciding with a transfer restarts the count at that transfer.
  always_comb begin
    cnt_a_d = cnt_a_q + {31'd0, a_fire};
    cnt_b_d = cnt_b_q + {31'd0, b_fire};
    if (cnt_clr) begin
      cnt_a_d = {31'd0, a_fire};
      cnt_b_d = {31'd0, b_fire};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;
`endif

endmodule

// File: tb/tb_demux_2_skid.sv
// Self-checking bench for demux_2_skid: scoreboard of accepted beats checked at the
// outputs, a backpressure vector table, and hand-written reset/stability/counter sequences.
module tb_demux_2_skid;
  import demux_2_skid_pkg::*;

  logic clk;
  logic rst_n;
`ifdef DEMUX_2_SKID_STATS_EN
  logic        cnt_clr;
  logic [31:0] cnt_a;
  logic [31:0] cnt_b;
`endif

  demux_2_skid_if #(.WIDTH(32)) bus ();

  demux_2_skid #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus)
`ifdef DEMUX_2_SKID_STATS_EN
    ,
    .cnt_clr (cnt_clr),
    .cnt_a   (cnt_a),
    .cnt_b   (cnt_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        in_valid;
    logic        in_sel;
    logic [31:0] in_data;
    logic        a_ready;
    logic        b_ready;
    logic        exp_in_ready;
    logic        exp_a_valid;
    logic        exp_b_valid;
    logic        chk_data;
    logic [31:0] exp_data;
  } vec_t;

  vec_t        vt [7];
  logic [32:0] sb_q [$];
  int          checks = 0;
  int          passed = 0;
  int          a_n = 0;
  int          b_n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
  endtask

  // Called at each negedge just before the next active edge: retire and accept beats.
  task automatic monitor();
    logic [32:0] e;
    logic        a_fire, b_fire;
    a_fire = bus.a_valid & bus.a_ready;
    b_fire = bus.b_valid & bus.b_ready;
    if (a_fire || b_fire) begin
      if (sb_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_beat actual=a%0b/b%0b data=%h required=none", a_fire, b_fire, bus.a_data);
      end else begin
        e = sb_q.pop_front();
        chk("out_port", 32'(b_fire), 32'(e[32]));
        chk("out_data", b_fire ? bus.b_data : bus.a_data, e[31:0]);
        $display("beat out port=%s data=%h", b_fire ? "B" : "A", b_fire ? bus.b_data : bus.a_data);
      end
      if (a_fire) a_n++;
      if (b_fire) b_n++;
    end
    if (bus.in_valid && bus.in_ready) sb_q.push_back({bus.in_sel, bus.in_data});
  endtask

  task automatic cyc();
    monitor();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic s, input logic [31:0] d);
    bus.in_valid = v;
    bus.in_sel   = s;
    bus.in_data  = d;
  endtask

  initial begin
    vt[0] = '{1'b1, 1'b0, 32'hA, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vt[1] = '{1'b1, 1'b1, 32'hB, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'hA};
    vt[2] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA};
    vt[3] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA};
    vt[4] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA};
    vt[5] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'hB};
    vt[6] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    bus.a_ready = 1'b0;
    bus.b_ready = 1'b0;
`ifdef DEMUX_2_SKID_STATS_EN
    cnt_clr = 1'b0;
`endif

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_a_valid", 32'(bus.a_valid), 32'd0);
    chk("rst_b_valid", 32'(bus.b_valid), 32'd0);
    chk("rst_data", bus.a_data, 32'd0);
    rst_n = 1'b1;
    cyc();
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

    // Single beat to B, 1-cycle latency
    bus.a_ready = 1'b1;
    bus.b_ready = 1'b1;
    drive(1'b1, SEL_B, 32'h1234_5678);
    cyc();
    drive(1'b0, 1'b0, 32'h0);
    chk("single_b_valid", 32'(bus.b_valid), 32'd1);
    chk("single_b_data", bus.b_data, 32'h1234_5678);
    chk("single_a_valid", 32'(bus.a_valid), 32'd0);
    cyc();
    chk("single_drained", 32'(bus.b_valid), 32'd0);

    // Streaming 8 beats, alternating destination
    a_n = 0;
    b_n = 0;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, (i % 2 == 0) ? SEL_B : SEL_A, 32'(i));
      chk("stream_in_ready", 32'(bus.in_ready), 32'd1);
      cyc();
    end
    drive(1'b0, 1'b0, 32'h0);
    cyc();
    chk("stream_a_count", 32'(a_n), 32'd4);
    chk("stream_b_count", 32'(b_n), 32'd4);

    // Backpressure table: A stalls with a B beat queued behind it
    for (int i = 0; i < 7; i++) begin
      drive(vt[i].in_valid, vt[i].in_sel, vt[i].in_data);
      bus.a_ready = vt[i].a_ready;
      bus.b_ready = vt[i].b_ready;
      chk("tbl_in_ready", 32'(bus.in_ready), 32'(vt[i].exp_in_ready));
      chk("tbl_a_valid", 32'(bus.a_valid), 32'(vt[i].exp_a_valid));
      chk("tbl_b_valid", 32'(bus.b_valid), 32'(vt[i].exp_b_valid));
      if (vt[i].chk_data)
        chk("tbl_data", vt[i].exp_b_valid ? bus.b_data : bus.a_data, vt[i].exp_data);
      $display("vec %0d in_ready=%0b a_valid=%0b b_valid=%0b", i, bus.in_ready, bus.a_valid, bus.b_valid);
      cyc();
    end

    // Stability under B backpressure
    bus.a_ready = 1'b1;
    bus.b_ready = 1'b0;
    drive(1'b1, SEL_B, 32'hCAFE_F00D);
    cyc();
    drive(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      chk("hold_b_valid", 32'(bus.b_valid), 32'd1);
      chk("hold_b_data", bus.b_data, 32'hCAFE_F00D);
      cyc();
    end
    bus.b_ready = 1'b1;
    cyc();
    chk("hold_released", 32'(bus.b_valid), 32'd0);

    // Asynchronous reset mid-cycle with two beats buffered
    bus.a_ready = 1'b0;
    bus.b_ready = 1'b0;
    drive(1'b1, SEL_A, 32'h11);
    cyc();
    drive(1'b1, SEL_B, 32'h22);
    cyc();
    drive(1'b0, 1'b0, 32'h0);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_a_valid", 32'(bus.a_valid), 32'd0);
    chk("async_b_valid", 32'(bus.b_valid), 32'd0);
    chk("async_in_ready", 32'(bus.in_ready), 32'd0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    bus.a_ready = 1'b1;
    bus.b_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_a_valid", 32'(bus.a_valid), 32'd0);
      chk("post_rst_b_valid", 32'(bus.b_valid), 32'd0);
      cyc();
    end

`ifdef DEMUX_2_SKID_STATS_EN
    chk("cnt_a_reset", cnt_a, 32'd0);
    chk("cnt_b_reset", cnt_b, 32'd0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, (i % 2 == 1) ? SEL_B : SEL_A, 32'h100 + 32'(i));
      cyc();
    end
    drive(1'b0, 1'b0, 32'h0);
    cyc();
    chk("cnt_a_3", cnt_a, 32'd3);
    chk("cnt_b_2", cnt_b, 32'd2);
    drive(1'b1, SEL_A, 32'h44);
    cyc();
    drive(1'b0, 1'b0, 32'h0);
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    chk("cnt_a_clr_xfer", cnt_a, 32'd1);
    chk("cnt_b_clr", cnt_b, 32'd0);
`endif

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
